// File: rtl/x3q16_mem_responder.sv
// ============================================================================
// Module  : x3q16_mem_responder
// Brief   : Single-port word memory responder with fixed wait-state latency,
//           one service per request level. Optional write guard enabled by
//           defining X3Q16_MEM_GUARD_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module x3q16_mem_responder #(
  parameter int          DEPTH_LOG2  = 8,
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] GUARD_BASE  = 16'hFF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        request,
  input  logic        request_type,
  input  logic [15:0] request_address,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        memory_ready,
  output logic        write_complete,
  output logic        memory_critical,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t                  r_state;
  logic [3:0]              r_count;
  logic                    r_type;
  logic [15:0]             r_addr;
  logic [15:0]             r_wdata;
  logic [15:0]             r_mem [0:(1<<DEPTH_LOG2)-1];

  logic [DEPTH_LOG2-1:0]   w_idx;
  logic                    w_reject;

  assign w_idx = r_addr[DEPTH_LOG2-1:0];

`ifdef X3Q16_MEM_GUARD_EN
  assign w_reject = r_type && (r_addr >= GUARD_BASE);
`else
  logic w_unused_bits;
  assign w_reject      = 1'b0;
  assign w_unused_bits = ^{GUARD_BASE, r_addr};
`endif

  // Array has no reset; a reset edge that coincides with RESP suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == S_RESP) && r_type && !w_reject) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_count         <= 4'd0;
      r_type          <= 1'b0;
      r_addr          <= 16'h0000;
      r_wdata         <= 16'h0000;
      read_data       <= 16'h0000;
      memory_ready    <= 1'b0;
      write_complete  <= 1'b0;
      memory_critical <= 1'b0;
      busy            <= 1'b0;
    end else begin
      memory_ready    <= 1'b0;
      write_complete  <= 1'b0;
      memory_critical <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (request) begin
            r_type  <= request_type;
            r_addr  <= request_address;
            r_wdata <= write_data;
            r_count <= 4'(WAIT_STATES);
            busy    <= 1'b1;
            r_state <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (!r_type) begin
            read_data    <= r_mem[w_idx];
            memory_ready <= 1'b1;
          end else if (w_reject) begin
            memory_critical <= 1'b1;
          end else begin
            write_complete <= 1'b1;
          end
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (!request) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_x3q16_mem_responder.sv
// ============================================================================
// Module  : tb_x3q16_mem_responder
// Brief   : Randomized self-checking bench for x3q16_mem_responder against a
//           transaction-level memory model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_x3q16_mem_responder;

  localparam int          DEPTH_LOG2  = 8;
  localparam int          WAIT_STATES = 2;
  localparam logic [15:0] GUARD_BASE  = 16'hFF00;
  localparam int          DEPTH       = 1 << DEPTH_LOG2;
`ifdef X3Q16_MEM_GUARD_EN
  localparam bit          GUARD_ON    = 1'b1;
`else
  localparam bit          GUARD_ON    = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        request;
  logic        request_type;
  logic [15:0] request_address;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        memory_ready;
  logic        write_complete;
  logic        memory_critical;
  logic        busy;

  logic [15:0] m_mem [0:DEPTH-1];
  logic [15:0] exp_rd;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  x3q16_mem_responder #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WAIT_STATES(WAIT_STATES),
    .GUARD_BASE (GUARD_BASE)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .request        (request),
    .request_type   (request_type),
    .request_address(request_address),
    .write_data     (write_data),
    .read_data      (read_data),
    .memory_ready   (memory_ready),
    .write_complete (write_complete),
    .memory_critical(memory_critical),
    .busy           (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One full transaction: the response is due WAIT_STATES+1 cycles after the
  // acceptance edge; request is then held for 'extra' more cycles.
  task automatic do_txn(input logic t, input logic [15:0] a, input logic [15:0] d,
                        input int extra, input bit scramble);
    logic [2:0] exp_p;
    int         idx;
    bit         rej;
    idx = int'(a) % DEPTH;
    rej = GUARD_ON && t && (a >= GUARD_BASE);
    @(negedge clk);
    request = 1'b1; request_type = t; request_address = a; write_data = d;
    @(posedge clk);
    if (scramble) begin
      #1;
      request_type    = ~t;
      request_address = 16'($urandom);
      write_data      = 16'($urandom);
    end
    for (int j = 0; j <= WAIT_STATES + 1 + extra; j++) begin
      @(negedge clk);
      exp_p = 3'b000;
      if (j == WAIT_STATES + 1) begin
        if (!t) begin
          exp_rd = m_mem[idx];
          exp_p  = 3'b100;
        end else if (rej) begin
          exp_p = 3'b001;
        end else begin
          m_mem[idx] = d;
          exp_p      = 3'b010;
        end
      end
      check_eq("pulses", {29'd0, memory_ready, write_complete, memory_critical}, {29'd0, exp_p});
      check_eq("busy", {31'd0, busy}, 32'd1);
      check_eq("read_data", {16'd0, read_data}, {16'd0, exp_rd});
    end
    request = 1'b0;
    @(negedge clk);
    check_eq("busy_drop", {31'd0, busy}, 32'd0);
    check_eq("pulses_idle", {29'd0, memory_ready, write_complete, memory_critical}, 32'd0);
  endtask

  task automatic reset_during_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    request = 1'b1; request_type = 1'b1; request_address = a; write_data = d;
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b1;
    request = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    exp_rd = 16'h0000;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_rdata", {16'd0, read_data}, 32'd0);
    for (int k = 0; k < WAIT_STATES + 3; k++) begin
      @(negedge clk);
      check_eq("rst_no_pulse", {29'd0, memory_ready, write_complete, memory_critical}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; request = 1'b0; request_type = 1'b0;
    request_address = 16'h0000; write_data = 16'h0000;
    exp_rd = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_eq("reset_rdata", {16'd0, read_data}, 32'd0);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_pulses", {29'd0, memory_ready, write_complete, memory_critical}, 32'd0);

    // Give every word a known value so later reads have a defined expectation.
    for (int i = 0; i < DEPTH; i++) do_txn(1'b1, 16'(i), 16'($urandom), 0, 1'b0);

    do_txn(1'b1, 16'h0010, 16'hBEEF, 0, 1'b0);
    do_txn(1'b0, 16'h0010, 16'h0000, 0, 1'b0);
    check_eq("beef_read", {16'd0, read_data}, 32'h0000BEEF);

    do_txn(1'b0, 16'h0010, 16'h0000, 10 - (WAIT_STATES + 2), 1'b0);

    do_txn(1'b1, 16'h0105, 16'h1234, 0, 1'b0);
    do_txn(1'b0, 16'h0005, 16'h0000, 0, 1'b0);
    check_eq("alias_read", {16'd0, read_data}, 32'h00001234);

    reset_during_write(16'h0020, 16'hAAAA);
    do_txn(1'b0, 16'h0020, 16'h0000, 0, 1'b0);

    do_txn(1'b1, 16'hFF01, 16'h5555, 0, 1'b0);
    do_txn(1'b0, 16'h0001, 16'h0000, 0, 1'b0);

    do_txn(1'b1, 16'h0033, 16'hC0DE, 1, 1'b1);
    do_txn(1'b0, 16'h0033, 16'h0000, 0, 1'b1);

    for (int n = 0; n < 300; n++) begin
      do_txn(1'($urandom), 16'($urandom), 16'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
